// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, issues word fetches over req/gnt/rvalid,
// buffers responses in a small FIFO and hands {instr, pc} to decode.
module instr_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IBUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        id_ready,
  output logic        fetch_misalign
);

  localparam int PW  = $clog2(IBUF_DEPTH);
  localparam int CW  = PW + 1;
  localparam int CW1 = CW + 1;
  localparam logic [CW:0] DEPTH_W = CW1'(IBUF_DEPTH);

  logic [31:0]    pc;
  logic [31:0]    resp_pc;
  logic [CW-1:0]  count;
  logic [CW-1:0]  outstanding;
  logic [CW-1:0]  outstanding_next;
  logic [CW-1:0]  drop;
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [31:0]    buf_instr [IBUF_DEPTH];
  logic [31:0]    buf_pc    [IBUF_DEPTH];
  logic [CW:0]    occupancy;
  logic           fire_gnt;
  logic           discard;
  logic           push;
  logic           pop;
  logic [31:0]    redirect_target;

  // Every in-flight request owns a buffer slot, so responses never need backpressure.
  assign occupancy        = {1'b0, outstanding} + {1'b0, count};
  assign imem_req         = rst_n && (occupancy < DEPTH_W) && !redirect_valid;
  assign imem_addr        = pc;
  assign fire_gnt         = imem_req && imem_gnt;
  assign discard          = imem_rvalid && (drop != '0);
  assign push             = imem_rvalid && (drop == '0) && !redirect_valid;
  assign pop              = if_valid && id_ready && !redirect_valid;
  assign outstanding_next = outstanding + CW'(fire_gnt) - CW'(imem_rvalid);
  assign redirect_target  = {redirect_pc[31:2], 2'b00};

  assign if_valid = (count != '0);
  assign if_instr = if_valid ? buf_instr[rd_ptr] : 32'h0;
  assign if_pc    = if_valid ? buf_pc[rd_ptr]    : 32'h0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc             <= RESET_PC;
      resp_pc        <= RESET_PC;
      count          <= '0;
      outstanding    <= '0;
      drop           <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      fetch_misalign <= 1'b0;
    end else begin
      outstanding    <= outstanding_next;
      fetch_misalign <= redirect_valid && (redirect_pc[1:0] != 2'b00);
      if (redirect_valid) begin
        // Everything still in flight belongs to the old path.
        pc      <= redirect_target;
        resp_pc <= redirect_target;
        count   <= '0;
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        drop    <= outstanding_next;
      end else begin
        if (fire_gnt) pc <= pc + 32'd4;
        if (discard) drop <= drop - CW'(1);
        if (push) begin
          wr_ptr  <= wr_ptr + PW'(1);
          resp_pc <= resp_pc + 32'd4;
        end
        if (pop) rd_ptr <= rd_ptr + PW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_instr[wr_ptr] <= imem_rdata;
      buf_pc[wr_ptr]    <= resp_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) assert (occupancy <= DEPTH_W);
  end

endmodule
